demux_regbank: RTL
==================

Name: demux_regbank

Overview:
Parametrised N-channel demultiplexing register bank. It is the successor to the fixed 8-way registered demux. A valid/ready transaction routes value_i to the channel addressed by sel_i, with a selectable operation: load, accumulate, broadcast or clear. The bank keeps per-channel "fresh" flags for downstream consumers and provides a multi-cycle sweep-clear sequencer. It sits between a single producer and N independent consumers of configuration or status words.

Parameters:
NumChannels, 8, number of output channels (>= 2)
Width, 5, bits per channel word
SelW, $clog2(NumChannels), select width (derived localparam, not overridable)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
valid_i  in  1  transaction request
ready_o  out  1  bank can accept a transaction this cycle
sel_i  in  SelW  target channel
op_i  in  2  operation (LOAD/ACC/BCAST/CLR)
value_i  in  Width  operand
clear_all_i  in  1  request sweep-clear of all channels
ack_i  in  NumChannels  per-channel consumer acknowledge; clears the fresh flag
data_o  out  NumChannels*Width  channel words; channel k occupies bits [k*Width +: Width]
fresh_o  out  NumChannels  sticky per-channel "updated since ack" flags
ovf_o  out  1  one-cycle pulse: an ACC wrapped
err_o  out  1  one-cycle pulse: an accepted transaction had sel_i >= NumChannels
busy_o  out  1  sweep in progress
done_o  out  1  one-cycle pulse when the sweep finishes

Behaviour:
- One clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset (rst_i high at a clock edge): all data_o=0, fresh_o=0, ovf_o=0, err_o=0, done_o=0, busy_o=0, FSM=IDLE, sweep index=0. Reset overrides everything, including a sweep in progress.
- Handshake: ready_o = (state==IDLE). A transaction is accepted on a clock edge where valid_i && ready_o. Effects are visible on data_o/fresh_o one cycle after acceptance. No accept occurs while busy. The producer holds valid_i and its payload until accepted.
- Operations on an accepted transaction:
  - op 00 LOAD: ch[sel] <= value_i.
  - op 01 ACC: ch[sel] <= (ch[sel] + value_i) mod 2^Width. ovf_o pulses the next cycle if the carry-out is 1.
  - op 10 BCAST: every channel <= value_i. All fresh bits set. sel_i ignored; err_o never fires for BCAST.
  - op 11 CLR: ch[sel] <= 0. fresh[sel] set.
- LOAD and ACC also set fresh[sel].
- Out-of-range sel_i (non-power-of-2 NumChannels, non-BCAST op): transaction is accepted and consumed with no data/fresh change. err_o pulses the next cycle.
- fresh flags: set by a write to that channel, cleared by ack_i[k]. A write and ack to the same channel in the same cycle leaves the flag set.
- FSM states IDLE and SWEEP:
  - IDLE -> SWEEP on clear_all_i. If a transaction is accepted in that same cycle, it executes; the sweep starts the next cycle and clears it anyway.
  - In SWEEP: busy_o=1, ready_o=0. Each cycle it clears ch[idx] and fresh[idx], then idx++.
  - After idx==NumChannels-1 is cleared: done_o pulses in that same cycle's registered output, the FSM returns to IDLE and idx resets to 0.
  - A sweep takes exactly NumChannels cycles. clear_all_i is ignored while in SWEEP.
  - ack_i is still honoured during SWEEP.
- All outputs are registered except ready_o and busy_o, which decode the state register.

Decomposition:
- Package demux_regbank_pkg holds:
  - op_e enum: OP_LOAD=2'b00, OP_ACC=2'b01, OP_BCAST=2'b10, OP_CLR=2'b11
  - state_e enum: IDLE, SWEEP
- Sub-module demux_regbank_chan: one channel. Holds the data register, fresh flag and wrap adder with carry-out. Inputs: wr_en, op, value, clr, ack. Instantiated NumChannels times via generate.
- Top level holds: FSM, sweep index, sel decode, range check, ovf/err pulse registers.

Test Plan:
- Reset, then LOAD ch3=5'h1A -> next cycle data ch3=1A, fresh_o=8'b0000_1000, all other channels 0. ack_i[3]=1 -> fresh_o=0.
- ACC ch0: LOAD 5'h1E, then ACC 5'h03 -> ch0=5'h01, ovf_o high exactly one cycle. ACC 5'h01 -> ch0=5'h02, no ovf_o.
- BCAST 5'h15 -> all 8 channels 15, fresh_o=8'hFF. Same-cycle ack_i=8'hFF with a LOAD to ch2 -> fresh_o=8'b0000_0100.
- clear_all_i pulse after BCAST -> busy_o/ready_o flip the next cycle. Channels clear in order 0..7, one per cycle. done_o pulses on the 8th sweep cycle. valid_i held during the sweep is accepted only after return to IDLE.
- NumChannels=5, Width=12: LOAD with sel_i=6 -> err_o one-cycle pulse, no data change. LOAD sel_i=4 value 12'hABC -> ch4=ABC.
- rst_i asserted mid-sweep (cycle 3) -> next cycle all zero, IDLE, ready_o=1, no done_o.

Source files
------------

// File: rtl/demux_regbank_pkg.sv
// Shared types for the demultiplexing register bank.
package demux_regbank_pkg;

  // Transaction operation carried on op_i.
  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_ACC   = 2'b01,
    OP_BCAST = 2'b10,
    OP_CLR   = 2'b11
  } op_e;

  // Bank sequencer state: accepting transactions, or sweeping channels to zero.
  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

endpackage

// File: rtl/demux_regbank_chan.sv
// One channel of the register bank: data word, sticky fresh flag and wrap adder.
module demux_regbank_chan
  import demux_regbank_pkg::*;
#(
  parameter int unsigned Width = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  op_e              op_i,
  input  logic [Width-1:0] value_i,
  input  logic             clr_i,
  input  logic             ack_i,
  output logic [Width-1:0] data_o,
  output logic             fresh_o,
  output logic             carry_o
);

  logic [Width-1:0] data_q, data_d;
  logic             fresh_q, fresh_d;
  logic [Width:0]   sum;

  assign sum     = {1'b0, data_q} + {1'b0, value_i};
  assign carry_o = sum[Width];
  assign data_o  = data_q;
  assign fresh_o = fresh_q;

  // Next data word and fresh flag; a sweep clear wins, then a write, then an ack.
  always_comb begin
    data_d  = data_q;
    fresh_d = fresh_q;
    if (clr_i) begin
      data_d  = '0;
      fresh_d = 1'b0;
    end else if (wr_en_i) begin
      fresh_d = 1'b1;
      unique case (op_i)
        OP_LOAD:  data_d = value_i;
        OP_ACC:   data_d = sum[Width-1:0];
        OP_BCAST: data_d = value_i;
        OP_CLR:   data_d = '0;
        default:  data_d = data_q;
      endcase
    end else if (ack_i) begin
      fresh_d = 1'b0;
    end
  end

  // Channel state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      fresh_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      fresh_q <= fresh_d;
    end
  end

endmodule

// File: rtl/demux_regbank.sv
// N-channel demultiplexing register bank with sweep-clear sequencer.
module demux_regbank
  import demux_regbank_pkg::*;
#(
  parameter int unsigned NumChannels = 8,
  parameter int unsigned Width       = 5
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [$clog2(NumChannels)-1:0] sel_i,
  input  logic [1:0]                   op_i,
  input  logic [Width-1:0]             value_i,
  input  logic                         clear_all_i,
  input  logic [NumChannels-1:0]       ack_i,
  output logic [NumChannels*Width-1:0] data_o,
  output logic [NumChannels-1:0]       fresh_o,
  output logic                         ovf_o,
  output logic                         err_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int unsigned SelW = $clog2(NumChannels);
  localparam logic [SelW:0]   NumChW  = (SelW + 1)'(NumChannels);
  localparam logic [SelW-1:0] LastIdx = SelW'(NumChannels - 1);

  state_e           state_q;
  logic [SelW-1:0]  idx_q;
  logic             done_q;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  op_e              op;
  logic             accept;
  logic             in_range;
  logic [NumChannels-1:0] hit;
  logic [NumChannels-1:0] wr_en;
  logic [NumChannels-1:0] clr;
  logic [NumChannels-1:0] carry;

  assign op       = op_e'(op_i);
  assign ready_o  = (state_q == IDLE);
  assign busy_o   = (state_q == SWEEP);
  assign accept   = valid_i && ready_o;
  assign in_range = ({1'b0, sel_i} < NumChW);

  // Per-channel select decode, write enables and sweep clear strobes.
  always_comb begin
    for (int k = 0; k < NumChannels; k++) begin
      hit[k]   = (sel_i == SelW'(k));
      wr_en[k] = accept && ((op == OP_BCAST) || hit[k]);
      clr[k]   = busy_o && (idx_q == SelW'(k));
    end
  end

  // Pulse conditions; an out-of-range sel never matches a channel so it cannot flag ovf.
  always_comb begin
    ovf_d = accept && (op == OP_ACC) && |(carry & hit);
    err_d = accept && (op != OP_BCAST) && !in_range;
  end

  for (genvar k = 0; k < NumChannels; k++) begin : g_chan
    demux_regbank_chan #(
      .Width(Width)
    ) u_chan (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .wr_en_i (wr_en[k]),
      .op_i    (op),
      .value_i (value_i),
      .clr_i   (clr[k]),
      .ack_i   (ack_i[k]),
      .data_o  (data_o[k*Width +: Width]),
      .fresh_o (fresh_o[k]),
      .carry_o (carry[k])
    );
  end

  // Sweep sequencer: one channel cleared per cycle, done pulses with the last one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (clear_all_i) begin
            state_q <= SWEEP;
            idx_q   <= '0;
          end
        end
        SWEEP: begin
          if (idx_q == LastIdx) begin
            state_q <= IDLE;
            idx_q   <= '0;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= '0;
        end
      endcase
    end
  end

  // Registered one-cycle status pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      err_q <= err_d;
    end
  end

  assign ovf_o  = ovf_q;
  assign err_o  = err_q;
  assign done_o = done_q;

endmodule
